// File: rtl/morse_pkg.sv
// rtl/morse_pkg.sv - shared types and defaults for the Morse timing front-end
package morse_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MARK  = 2'd1,
    SPACE = 2'd2
  } state_t;

  typedef enum logic {
    DOT  = 1'b0,
    DASH = 1'b1
  } elem_t;

  localparam int DEF_DASH_TH   = 3;
  localparam int DEF_LETTER_TH = 3;
  localparam int DEF_WORD_TH   = 7;
  localparam int MAX_ELEMS     = 5;

endpackage

// File: rtl/run_counter.sv
// rtl/run_counter.sv - saturating run-length counter with load-to-one and increment
module run_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_one,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load_one) begin
      cnt <= CNT_W'(1);
    end else if (inc && (cnt != {CNT_W{1'b1}})) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/morse_tokenizer.sv
// rtl/morse_tokenizer.sv - mark/space timing, dot/dash classification and letter packing
// Optional MORSE_DEGLITCH_EN: synchronize and glitch-filter key_in before timing.
module morse_tokenizer
  import morse_pkg::*;
#(
  parameter int CNT_W     = 8,
  parameter int DASH_TH   = DEF_DASH_TH,
  parameter int LETTER_TH = DEF_LETTER_TH,
  parameter int WORD_TH   = DEF_WORD_TH
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_in,
  output logic       elem_valid,
  output logic       elem_dash,
  output logic [4:0] code,
  output logic [2:0] len,
  output logic       code_err,
  output logic       code_valid,
  input  logic       code_ready,
  output logic       overrun,
  output logic       word_end
);

  logic key;

`ifdef MORSE_DEGLITCH_EN
  logic sync1, sync2, key_f;

  // A new level is taken only once two consecutive synchronized samples agree.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      key_f <= 1'b0;
    end else begin
      sync1 <= key_in;
      sync2 <= sync1;
      if (sync1 == sync2) key_f <= sync2;
    end
  end

  assign key = key_f;
`else
  assign key = key_in;
`endif

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             load_one, inc;
  logic [4:0]       acc;
  logic [2:0]       acc_len;
  logic             err_flag;
  logic             is_dash, letter_hit, word_hit;

  always_comb begin
    load_one = 1'b0;
    inc      = 1'b0;
    case (state)
      IDLE:    load_one = key;
      MARK:    begin load_one = !key; inc = key; end
      SPACE:   begin load_one = key;  inc = !key; end
      default: load_one = 1'b0;
    endcase
  end

  run_counter #(.CNT_W(CNT_W)) u_run_counter (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_one (load_one),
    .inc      (inc),
    .cnt      (cnt)
  );

  // Thresholds compare against the pre-increment count: this edge makes it cnt+1.
  assign is_dash    = (cnt >= CNT_W'(DASH_TH));
  assign letter_hit = (cnt == CNT_W'(LETTER_TH - 1));
  assign word_hit   = (cnt == CNT_W'(WORD_TH - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      elem_valid <= 1'b0;
      elem_dash  <= 1'b0;
      code       <= '0;
      len        <= '0;
      code_err   <= 1'b0;
      code_valid <= 1'b0;
      overrun    <= 1'b0;
      word_end   <= 1'b0;
      acc        <= '0;
      acc_len    <= '0;
      err_flag   <= 1'b0;
    end else begin
      elem_valid <= 1'b0;
      overrun    <= 1'b0;
      word_end   <= 1'b0;
      if (code_valid && code_ready) code_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (key) state <= MARK;
        end
        MARK: begin
          if (!key) begin
            elem_valid <= 1'b1;
            elem_dash  <= is_dash;
            if (acc_len == 3'(MAX_ELEMS)) begin
              err_flag <= 1'b1;
            end else begin
              acc     <= {acc[3:0], is_dash};
              acc_len <= acc_len + 3'd1;
            end
            state <= SPACE;
          end
        end
        SPACE: begin
          if (key) begin
            state <= MARK;
          end else begin
            if (letter_hit) begin
              code       <= acc;
              len        <= acc_len;
              code_err   <= err_flag;
              code_valid <= 1'b1;
              overrun    <= code_valid && !code_ready;
              acc        <= '0;
              acc_len    <= '0;
              err_flag   <= 1'b0;
            end
            if (word_hit) begin
              word_end <= 1'b1;
              state    <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/morse_tokenizer.md
Name: morse_tokenizer

Overview:
Front-end timing stage of the Morse decoder. Samples the keyed tone input every clock and measures mark and space run lengths with a saturating counter. Classifies each mark as dot or dash, packs the marks into a letter code, and reports letter and word boundaries. Its output feeds the letter-lookup stage through a valid/ready handshake.

Parameters:
CNT_W, 8, width of the run-length counter; the counter saturates at 2^CNT_W-1.
DASH_TH, 3, a mark lasting >= DASH_TH cycles is a dash; a shorter mark is a dot.
LETTER_TH, 3, a space lasting LETTER_TH cycles ends the current letter.
WORD_TH, 7, a space lasting WORD_TH cycles ends the word. Legal range: 2 <= LETTER_TH < WORD_TH < 2^CNT_W-1.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  synchronous reset, active-low
key_in  in  1  1 = tone present (mark), 0 = silence (space)
elem_valid  out  1  one-cycle pulse: one mark has been classified
elem_dash  out  1  class of that mark: 1 = dash, 0 = dot; qualified by elem_valid
code  out  5  letter code, first element at bit len-1, last element at bit 0; dash = 1
len  out  3  number of elements in the letter, 0..5
code_err  out  1  the letter had more than 5 elements
code_valid  out  1  letter available on code, len and code_err
code_ready  in  1  downstream accepts the letter
overrun  out  1  one-cycle pulse: an unaccepted letter was overwritten
word_end  out  1  one-cycle pulse at the end of a word

Behaviour:
- Synchronous, active-low reset, taking effect at the next clk edge, including mid-letter. Every output and every internal register resets to 0; the state resets to IDLE.
- All outputs are registered. An event is visible 1 cycle after the clk edge that sampled the key_in level causing it.
- cnt is the number of consecutive sampled cycles at the current level, counting the first cycle. It saturates and never wraps.
- IDLE: key_in=1 -> go to MARK with cnt=1. Otherwise stay in IDLE; no pulses are produced.
- MARK: key_in=1 -> cnt increments. key_in=0 -> pulse elem_valid with elem_dash=(cnt>=DASH_TH), then go to SPACE with cnt=1.
  - The element is appended to the accumulator as acc={acc[3:0],elem_dash} and acc_len increments.
  - If acc_len is already 5, acc is left unchanged and err_flag is set.
- SPACE: key_in=1 -> go to MARK with cnt=1 (same letter while cnt<LETTER_TH). key_in=0 -> cnt increments, then:
  - When cnt reaches LETTER_TH: load code/len/code_err from acc/acc_len/err_flag, set code_valid, and clear the accumulator and err_flag.
  - When cnt reaches WORD_TH: pulse word_end once and go to IDLE.
- Handshake:
  - code, len and code_err stay stable while code_valid=1.
  - code_valid&code_ready at an edge clears code_valid.
  - A letter load in the same cycle as code_ready=1: the old letter is accepted, the new one is loaded, and code_valid stays 1.
  - A letter load while code_valid=1 and code_ready=0: the new letter overwrites the old one and overrun pulses.
- A space that begins after a letter boundary starts a new letter. A mark that arrives between LETTER_TH and WORD_TH does not produce word_end.

Optional Feature:
MORSE_DEGLITCH_EN
- Defined: key_in passes through a 2-flop synchronizer. A level change is accepted only after 2 consecutive equal synchronized samples, so single-cycle glitches are ignored. Every event gains 3 cycles of latency, and run lengths are measured on the filtered signal.
- Undefined: key_in is used directly with no added latency.

Decomposition:
- Package morse_pkg:
  - state encoding IDLE/MARK/SPACE (2 bits)
  - default DASH_TH/LETTER_TH/WORD_TH
  - MAX_ELEMS=5
  - element encoding DOT=0, DASH=1
- Sub-module run_counter: a saturating CNT_W-bit counter with load-1 and increment inputs, instantiated once.

Test Plan (DASH_TH=3, LETTER_TH=3, WORD_TH=7, code_ready=1 unless stated):
- Key high 1, low 1, high 3, low 3 -> elem pulses dot then dash; code=5'b00001, len=2, code_valid for 1 cycle, code_err=0.
- Mark of 2 cycles then mark of 3 cycles (space 1 between) -> elem_dash=0, then elem_dash=1; a mark of 300 cycles saturates cnt and still yields a dash.
- After letter "A", key low for 7 cycles -> code_valid 1 cycle after the 3rd low cycle; word_end exactly once after the 7th low cycle; state IDLE; no further pulses.
- Six dots (1 high/1 low each), then low 3 -> len=5, code=5'b00000, code_err=1; the next letter has code_err=0.
- code_ready=0, letters "E" then "T" -> code_valid stays 1; code changes to 5'b00001 with len=1; overrun pulses once.
- rst_n=0 for one edge in the middle of a mark -> all outputs 0, state IDLE; the next 1-cycle mark produces a dot, with no residual elements in the accumulator.
